// File: rtl/memory_access_pkg.sv
// memory_access_pkg: access-size encodings, FSM states and alignment helper for the memory access unit
package memory_access_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  typedef enum logic [2:0] {IDLE, LOAD_WAIT, RMW_READ, RMW_WRITE, DBG_WAIT} state_t;
  // Size 2'b11 is treated as a word so every encoding has a defined alignment rule
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return size[1] ? off != 2'b00 : size[0] & off[0];
  endfunction
endpackage

// File: rtl/memory_access_dm_bank.sv
// dm_bank: word storage with one write port and a read path delayed to MEM_LATENCY
module dm_bank #(
  parameter int NB_DATA = 32,
  parameter int NB_MEM_ADDR = 7,
  parameter int MEM_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [NB_MEM_ADDR-1:0] waddr,
  input  logic [NB_DATA-1:0]     wdata,
  input  logic [NB_MEM_ADDR-1:0] raddr,
  output logic [NB_DATA-1:0]     rdata
);
  logic [NB_DATA-1:0] mem [2**NB_MEM_ADDR];
  // Single write port; contents are deliberately never reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  // rdata shows the word addressed MEM_LATENCY-1 cycles ago so the caller's output register lands it at T+MEM_LATENCY
  if (MEM_LATENCY == 1) begin : g_comb
    assign rdata = mem[raddr];
  end else begin : g_pipe
    logic [NB_DATA-1:0] dly [MEM_LATENCY-1];
    // Read-data delay line
    always_ff @(posedge clk) begin
      dly[0] <= mem[raddr];
      for (int i = 1; i < MEM_LATENCY - 1; i++) dly[i] <= dly[i-1];
    end
    assign rdata = dly[MEM_LATENCY-2];
  end
endmodule

// File: rtl/memory_access_unit.sv
// memory_access_unit: MEM stage with multi-cycle loads, read-modify-write sub-word stores and a debug read port
module memory_access_unit
  import memory_access_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 32,
  parameter int NB_MEM_ADDR = 7,
  parameter int MEM_LATENCY = 2,
  parameter int NB_REG = 5
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_valid,
  input  logic                   i_mem_read,
  input  logic                   i_mem_write,
  input  logic [1:0]             i_size,
  input  logic                   i_signed,
  input  logic [NB_ADDR-1:0]     i_alu_result,
  input  logic [NB_DATA-1:0]     i_write_data,
  input  logic [NB_REG-1:0]      i_selected_reg,
  input  logic                   i_reg_write,
  input  logic                   i_mem_to_reg,
  input  logic                   i_debug_unit_flag,
  input  logic [NB_MEM_ADDR-1:0] i_debug_read_addr,
  input  logic                   i_debug_read_enable,
  output logic                   o_stall,
  output logic                   o_valid,
  output logic [NB_DATA-1:0]     o_mem_data,
  output logic [NB_ADDR-1:0]     o_alu_result,
  output logic [NB_REG-1:0]      o_selected_reg,
  output logic                   o_reg_write,
  output logic                   o_mem_to_reg,
  output logic                   o_misaligned,
  output logic [NB_DATA-1:0]     o_debug_data,
  output logic                   o_debug_valid
);
  localparam logic SHORT = MEM_LATENCY == 1;
  localparam logic [3:0] LAST = 4'(MEM_LATENCY - 1);
  state_t state, state_next;
  logic [3:0] cnt;
  logic idle, accept, mis, finish, load_done, dbg_done, capture, we;
  logic [NB_ADDR-1:0] req_addr, cur_addr;
  logic [15:0] req_wdata, cur_wdata;
  logic [1:0] req_size, cur_size;
  logic req_signed, cur_signed, req_reg_write, cur_reg_write, req_mem_to_reg, cur_mem_to_reg;
  logic [NB_REG-1:0] req_reg, cur_reg;
  logic [NB_MEM_ADDR-1:0] in_idx, req_idx, waddr, raddr;
  logic [NB_DATA-1:0] wdata, rdata, rmw_data;

  function automatic logic [NB_DATA-1:0] extract(input logic [NB_DATA-1:0] w, input logic [1:0] off,
                                                 input logic [1:0] size, input logic sgn);
    logic [7:0] b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = w[{off[1], 4'b0000} +: 16];
    return size[1] ? w : size[0] ? {{(NB_DATA-16){sgn & h[15]}}, h} : {{(NB_DATA-8){sgn & b[7]}}, b};
  endfunction

  function automatic logic [NB_DATA-1:0] merge(input logic [NB_DATA-1:0] w, input logic [1:0] off,
                                               input logic half, input logic [15:0] d);
    logic [NB_DATA-1:0] m;
    m = w;
    if (half) m[{off[1], 4'b0000} +: 16] = d;
    else m[{off, 3'b000} +: 8] = d[7:0];
    return m;
  endfunction

  assign idle = state == IDLE;
  assign accept = idle && i_valid && !i_debug_unit_flag;
  assign mis = (i_mem_read || i_mem_write) && misaligned(i_size, i_alu_result[1:0]);
  assign in_idx = i_alu_result[NB_MEM_ADDR+1:2];
  assign req_idx = req_addr[NB_MEM_ADDR+1:2];

  // Request fields come straight from the inputs in IDLE and from the captured copy while waiting
  always_comb begin
    cur_addr = idle ? i_alu_result : req_addr;
    cur_wdata = idle ? i_write_data[15:0] : req_wdata;
    cur_size = idle ? i_size : req_size;
    cur_signed = idle ? i_signed : req_signed;
    cur_reg = idle ? i_selected_reg : req_reg;
    cur_reg_write = idle ? i_reg_write : req_reg_write;
    cur_mem_to_reg = idle ? i_mem_to_reg : req_mem_to_reg;
  end

  // Next state, stall and memory port control
  always_comb begin
    state_next = state;
    o_stall = 1'b0;
    finish = 1'b0;
    load_done = 1'b0;
    dbg_done = 1'b0;
    capture = 1'b0;
    we = 1'b0;
    waddr = req_idx;
    wdata = rmw_data;
    raddr = in_idx;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!(i_mem_read || i_mem_write) || mis) begin
            finish = 1'b1;
          end else if (i_mem_read) begin
            o_stall = 1'b1;
            finish = SHORT;
            load_done = SHORT;
            state_next = SHORT ? IDLE : LOAD_WAIT;
          end else if (i_size[1]) begin
            we = 1'b1;
            waddr = in_idx;
            wdata = i_write_data;
            finish = 1'b1;
          end else begin
            o_stall = 1'b1;
            capture = SHORT;
            state_next = SHORT ? RMW_WRITE : RMW_READ;
          end
        end else if (i_debug_unit_flag) begin
          o_stall = i_valid;
          raddr = i_debug_read_addr;
          dbg_done = SHORT && i_debug_read_enable;
          state_next = (i_debug_read_enable && !SHORT) ? DBG_WAIT : IDLE;
        end
      end
      LOAD_WAIT: begin
        o_stall = 1'b1;
        finish = cnt == LAST;
        load_done = cnt == LAST;
        state_next = cnt == LAST ? IDLE : LOAD_WAIT;
      end
      RMW_READ: begin
        o_stall = 1'b1;
        capture = cnt == LAST;
        state_next = cnt == LAST ? RMW_WRITE : RMW_READ;
      end
      RMW_WRITE: begin
        o_stall = 1'b1;
        we = 1'b1;
        finish = 1'b1;
        state_next = IDLE;
      end
      DBG_WAIT: begin
        o_stall = i_valid;
        dbg_done = cnt == LAST;
        state_next = cnt == LAST ? IDLE : DBG_WAIT;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register and latency counter; the counter restarts at 1 on every IDLE cycle
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= IDLE;
      cnt <= 4'd0;
    end else begin
      state <= state_next;
      cnt <= idle ? 4'd1 : cnt + 4'd1;
    end
  end

  // Hold the accepted request for the wait states
  always_ff @(posedge i_clock) begin
    if (accept) begin
      req_addr <= i_alu_result;
      req_wdata <= i_write_data[15:0];
      req_size <= i_size;
      req_signed <= i_signed;
      req_reg <= i_selected_reg;
      req_reg_write <= i_reg_write;
      req_mem_to_reg <= i_mem_to_reg;
    end
  end

  // Merge the store lane into the word once the RMW read returns
  always_ff @(posedge i_clock) begin
    if (capture) rmw_data <= merge(rdata, cur_addr[1:0], cur_size[0], cur_wdata);
  end

  // Result registers: pulses clear every cycle, data holds until the next completion
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_valid <= 1'b0;
      o_misaligned <= 1'b0;
      o_debug_valid <= 1'b0;
      o_mem_data <= '0;
      o_alu_result <= '0;
      o_selected_reg <= '0;
      o_reg_write <= 1'b0;
      o_mem_to_reg <= 1'b0;
      o_debug_data <= '0;
    end else begin
      o_valid <= finish;
      o_misaligned <= finish && idle && mis;
      o_debug_valid <= dbg_done;
      if (finish) begin
        o_alu_result <= cur_addr;
        o_selected_reg <= cur_reg;
        o_reg_write <= cur_reg_write && !(idle && mis);
        o_mem_to_reg <= cur_mem_to_reg;
      end
      if (load_done) o_mem_data <= extract(rdata, cur_addr[1:0], cur_size, cur_signed);
      if (dbg_done) o_debug_data <= rdata;
    end
  end

  dm_bank #(
    .NB_DATA(NB_DATA),
    .NB_MEM_ADDR(NB_MEM_ADDR),
    .MEM_LATENCY(MEM_LATENCY)
  ) u_bank (
    .clk(i_clock),
    .we(we && !i_reset),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(raddr),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_memory_access_unit.sv
// tb_memory_access_unit: randomized transactions checked every cycle against a transaction-level model
module tb_memory_access_unit;
  localparam int L = 2;
  localparam int MAXC = 4096;

  typedef struct {
    bit v;
    bit mis;
    bit ld;
    bit dv;
    bit [31:0] data;
    bit [31:0] alu;
    bit [4:0] rg;
    bit rw;
    bit mtr;
    bit [31:0] dbg;
  } exp_t;

  logic i_clock = 1'b0, i_reset = 1'b1, i_valid = 1'b0, i_mem_read = 1'b0, i_mem_write = 1'b0;
  logic [1:0] i_size = 2'd0;
  logic i_signed = 1'b0, i_reg_write = 1'b0, i_mem_to_reg = 1'b0;
  logic [31:0] i_alu_result = '0, i_write_data = '0;
  logic [4:0] i_selected_reg = '0;
  logic i_debug_unit_flag = 1'b0, i_debug_read_enable = 1'b0;
  logic [6:0] i_debug_read_addr = '0;
  logic o_stall, o_valid, o_reg_write, o_mem_to_reg, o_misaligned, o_debug_valid;
  logic [31:0] o_mem_data, o_alu_result, o_debug_data;
  logic [4:0] o_selected_reg;

  int cyc = 0, n_cmp = 0, n_bad = 0;
  exp_t ex [MAXC];
  bit stall_x [MAXC];
  bit rst_at [MAXC];
  logic [31:0] mem_m [128];
  bit [31:0] h_data, h_alu, h_dbg;
  bit [4:0] h_rg;
  bit h_rw, h_mtr;

  memory_access_unit #(.MEM_LATENCY(L)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .i_mem_read(i_mem_read),
    .i_mem_write(i_mem_write), .i_size(i_size), .i_signed(i_signed), .i_alu_result(i_alu_result),
    .i_write_data(i_write_data), .i_selected_reg(i_selected_reg), .i_reg_write(i_reg_write),
    .i_mem_to_reg(i_mem_to_reg), .i_debug_unit_flag(i_debug_unit_flag),
    .i_debug_read_addr(i_debug_read_addr), .i_debug_read_enable(i_debug_read_enable),
    .o_stall(o_stall), .o_valid(o_valid), .o_mem_data(o_mem_data), .o_alu_result(o_alu_result),
    .o_selected_reg(o_selected_reg), .o_reg_write(o_reg_write), .o_mem_to_reg(o_mem_to_reg),
    .o_misaligned(o_misaligned), .o_debug_data(o_debug_data), .o_debug_valid(o_debug_valid)
  );

  always #5 i_clock = ~i_clock;
  always @(posedge i_clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] m_load(logic [31:0] w, logic [1:0] off, logic [1:0] size, bit sgn);
    logic [31:0] v;
    if (size == 2'd2) return w;
    if (size == 2'd1) begin
      v = (w >> (off[1] * 16)) & 32'hFFFF;
      if (sgn && v[15]) v = v | 32'hFFFF0000;
    end else begin
      v = (w >> (off * 8)) & 32'hFF;
      if (sgn && v[7]) v = v | 32'hFFFFFF00;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_merge(logic [31:0] w, logic [1:0] off, logic [1:0] size, logic [31:0] d);
    int sh;
    logic [31:0] mask;
    sh = size == 2'd1 ? off[1] * 16 : off * 8;
    mask = (size == 2'd1 ? 32'hFFFF : 32'hFF) << sh;
    return (w & ~mask) | ((d << sh) & mask);
  endfunction

  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  task automatic do_req(input bit rd, input bit wr, input logic [1:0] size, input bit sgn,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rg,
                        input bit rw, input bit mtr, output int stalls);
    int n, lat, s;
    bit mis;
    logic [1:0] off;
    logic [6:0] idx;
    n = cyc;
    off = addr[1:0];
    idx = addr[8:2];
    mis = (rd || wr) && ((size == 2'd1 && off[0]) || (size == 2'd2 && off != 2'd0));
    if (!(rd || wr) || mis) begin lat = 1; s = 0; end
    else if (rd) begin lat = L; s = L; end
    else if (size == 2'd2) begin lat = 1; s = 0; mem_m[idx] = wd; end
    else begin lat = L + 1; s = L + 1; mem_m[idx] = m_merge(mem_m[idx], off, size, wd); end
    ex[n+lat].v = 1'b1;
    ex[n+lat].mis = mis;
    ex[n+lat].ld = rd && !mis;
    ex[n+lat].data = (rd && !mis) ? m_load(mem_m[idx], off, size, sgn) : 32'd0;
    ex[n+lat].alu = addr;
    ex[n+lat].rg = rg;
    ex[n+lat].rw = rw && !mis;
    ex[n+lat].mtr = mtr;
    for (int i = 0; i < s; i++) stall_x[n+i] = 1'b1;
    i_valid = 1'b1; i_mem_read = rd; i_mem_write = wr; i_size = size; i_signed = sgn;
    i_alu_result = addr; i_write_data = wd; i_selected_reg = rg; i_reg_write = rw; i_mem_to_reg = mtr;
    stalls = 0;
    repeat (s == 0 ? 1 : s) begin
      #2;
      if (o_stall) stalls++;
      step();
    end
    i_valid = 1'b0;
  endtask

  task automatic do_dbg(input logic [6:0] idx, input bit v);
    int n;
    n = cyc;
    ex[n+L].dv = 1'b1;
    ex[n+L].dbg = mem_m[idx];
    for (int i = 0; i < L; i++) stall_x[n+i] = v;
    i_debug_unit_flag = 1'b1; i_debug_read_enable = 1'b1; i_debug_read_addr = idx; i_valid = v;
    step();
    i_debug_read_enable = 1'b0;
    repeat (L - 1) step();
    i_debug_unit_flag = 1'b0;
    i_valid = 1'b0;
  endtask

  task automatic abort_rmw();
    int n;
    n = cyc;
    stall_x[n] = 1'b1;
    i_valid = 1'b1; i_mem_read = 1'b0; i_mem_write = 1'b1; i_size = 2'd1; i_signed = 1'b0;
    i_alu_result = 32'h12; i_write_data = 32'hAAAA; i_selected_reg = 5'd3; i_reg_write = 1'b1;
    step();
    i_valid = 1'b0;
    i_reset = 1'b1;
    rst_at[n+1] = 1'b1;
    step();
    i_reset = 1'b0;
  endtask

  task automatic load_dbg();
    int n;
    n = cyc;
    ex[n+L].v = 1'b1; ex[n+L].ld = 1'b1; ex[n+L].data = mem_m[4];
    ex[n+L].alu = 32'h10; ex[n+L].rg = 5'd9; ex[n+L].rw = 1'b1; ex[n+L].mtr = 1'b1;
    ex[n+2*L].dv = 1'b1; ex[n+2*L].dbg = mem_m[4];
    for (int i = 0; i < L; i++) stall_x[n+i] = 1'b1;
    i_valid = 1'b1; i_mem_read = 1'b1; i_mem_write = 1'b0; i_size = 2'd2; i_signed = 1'b0;
    i_alu_result = 32'h10; i_selected_reg = 5'd9; i_reg_write = 1'b1; i_mem_to_reg = 1'b1;
    step();
    i_debug_unit_flag = 1'b1; i_debug_read_enable = 1'b1; i_debug_read_addr = 7'd4;
    repeat (L - 1) step();
    i_valid = 1'b0;
    step();
    i_debug_read_enable = 1'b0;
    repeat (L - 1) step();
    i_debug_unit_flag = 1'b0;
  endtask

  // Per-cycle comparison of every output against the model's schedule and held values
  always @(negedge i_clock) begin
    if (cyc < MAXC && !rst_at[cyc]) begin
      if (cyc > 0 && rst_at[cyc-1]) begin
        h_data = 0; h_alu = 0; h_dbg = 0; h_rg = 0; h_rw = 0; h_mtr = 0;
      end
      if (ex[cyc].v) begin
        h_alu = ex[cyc].alu; h_rg = ex[cyc].rg; h_rw = ex[cyc].rw; h_mtr = ex[cyc].mtr;
        if (ex[cyc].ld) h_data = ex[cyc].data;
      end
      if (ex[cyc].dv) h_dbg = ex[cyc].dbg;
      chk("o_valid", 32'(o_valid), 32'(ex[cyc].v));
      chk("o_debug_valid", 32'(o_debug_valid), 32'(ex[cyc].dv));
      chk("o_misaligned", 32'(o_misaligned), 32'(ex[cyc].v && ex[cyc].mis));
      chk("o_stall", 32'(o_stall), 32'(stall_x[cyc]));
      chk("o_mem_data", o_mem_data, h_data);
      chk("o_alu_result", o_alu_result, h_alu);
      chk("o_selected_reg", 32'(o_selected_reg), 32'(h_rg));
      chk("o_reg_write", 32'(o_reg_write), 32'(h_rw));
      chk("o_mem_to_reg", 32'(o_mem_to_reg), 32'(h_mtr));
      chk("o_debug_data", o_debug_data, h_dbg);
    end
  end

  initial begin
    int st, k;
    bit rd, wr;
    logic [31:0] addr;
    for (int i = 0; i < 4; i++) rst_at[i] = 1'b1;
    repeat (4) step();
    i_reset = 1'b0;
    chk("reset_valid", 32'(o_valid), 32'd0);
    chk("reset_mem_data", o_mem_data, 32'd0);
    for (int i = 0; i < 128; i++) do_req(1'b0, 1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, 5'(i), 1'b0, 1'b0, st);
    do_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 5'd1, 1'b0, 1'b0, st);
    do_req(1'b1, 1'b0, 2'd0, 1'b0, 32'h13, 32'd0, 5'd2, 1'b1, 1'b1, st);
    chk("byte_unsigned", o_mem_data, 32'h000000DE);
    do_req(1'b1, 1'b0, 2'd0, 1'b1, 32'h13, 32'd0, 5'd2, 1'b1, 1'b1, st);
    chk("byte_signed", o_mem_data, 32'hFFFFFFDE);
    do_req(1'b0, 1'b1, 2'd1, 1'b0, 32'h12, 32'h1234, 5'd0, 1'b0, 1'b0, st);
    chk("half_store_stall_cycles", 32'(st), 32'd3);
    do_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 5'd4, 1'b1, 1'b0, st);
    chk("half_merge_word", o_mem_data, 32'h1234BEEF);
    do_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h06, 32'd0, 5'd7, 1'b1, 1'b0, st);
    chk("misaligned_flag", 32'(o_misaligned), 32'd1);
    chk("misaligned_reg_write", 32'(o_reg_write), 32'd0);
    do_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h04, 32'd0, 5'd7, 1'b1, 1'b0, st);
    do_req(1'b1, 1'b1, 2'd0, 1'b0, 32'h10, 32'h55, 5'd5, 1'b1, 1'b1, st);
    chk("read_write_as_load", o_mem_data, 32'h000000EF);
    do_req(1'b1, 1'b0, 2'd2, 1'b0, 32'hFFFFFE10, 32'd0, 5'd6, 1'b1, 1'b0, st);
    chk("address_wrap", o_mem_data, 32'h1234BEEF);
    abort_rmw();
    do_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 5'd8, 1'b1, 1'b0, st);
    chk("abort_word_unchanged", o_mem_data, 32'h1234BEEF);
    load_dbg();
    chk("dbg_after_load_valid", 32'(o_debug_valid), 32'd1);
    chk("dbg_after_load_data", o_debug_data, 32'h1234BEEF);
    for (int t = 0; t < 300; t++) begin
      k = $urandom_range(0, 9);
      if (k == 0) begin
        do_dbg(7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)));
      end else begin
        rd = k <= 3;
        wr = k >= 3 && k <= 7;
        addr = $urandom;
        if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
        do_req(rd, wr, 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), addr, $urandom,
               5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), st);
      end
      if ($urandom_range(0, 3) == 0) step();
    end
    repeat (4) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
